// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MA stage (master) and a variable-latency memory (slave).
// Signals: mem_req/mem_we/mem_addr/mem_wdata out of the stage, mem_ack/mem_rdata back in.
interface mem_access_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MA stage: issues loads/stores over req/ack, stalls EX until ack, fills MA pipeline reg.
// Ports: clk, reset_n, *_ex inputs, stall_ma, mem (bus master), *_ma outputs, fwd_* (MA_FWD_EN).
module mem_access_stage #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 16,
  parameter int              REG_IDX_W = 5,
  parameter int              CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] LOAD_OP  = 4'b1100,
  parameter logic [CTRL_W-1:0] STORE_OP = 4'b1110
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_ex,
  input  logic [CTRL_W-1:0]    control_ex,
  input  logic [DATA_W-1:0]    result_ex,
  input  logic [DATA_W-1:0]    reg_data_ex,
  input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
  input  logic                 dest_reg_write_en_ex,
  output logic                 stall_ma,
  mem_access_stage_if.master   mem,
  output logic                 valid_ma,
  output logic [CTRL_W-1:0]    control_ma,
  output logic [DATA_W-1:0]    result_ma,
  output logic [DATA_W-1:0]    data_ma,
  output logic [REG_IDX_W-1:0] dest_reg_index_ma,
  output logic                 dest_reg_write_en_ma,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_index,
  output logic [DATA_W-1:0]    fwd_data
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;

  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic                 valid_q, valid_d;
  logic [CTRL_W-1:0]    control_q, control_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [REG_IDX_W-1:0] dest_idx_q, dest_idx_d;
  logic                 dest_we_q, dest_we_d;

  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              is_load, is_store, mem_op;

  assign is_load  = control_ex == LOAD_OP;
  assign is_store = control_ex == STORE_OP;
  // Gated by reset_n so a reset during WAIT drops the request at once.
  assign mem_op   = valid_ex && (is_load || is_store) && reset_n;

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req         = 1'b0;
    we          = 1'b0;
    addr        = '0;
    wdata       = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          req         = 1'b1;
          we          = is_store;
          addr        = result_ex[ADDR_W-1:0];
          wdata       = is_store ? reg_data_ex : '0;
          req_we_d    = we;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          if (!mem.mem_ack) state_d = WAIT;
        end
      end
      WAIT: begin
        req   = 1'b1;
        we    = req_we_q;
        addr  = req_addr_q;
        wdata = req_wdata_q;
        if (mem.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_ma      = req && !mem.mem_ack;
  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  always_comb begin
    valid_d    = 1'b0;
    dest_we_d  = 1'b0;
    control_d  = control_q;
    result_d   = result_q;
    data_d     = data_q;
    dest_idx_d = dest_idx_q;
    if (!stall_ma) begin
      valid_d    = valid_ex;
      dest_we_d  = dest_reg_write_en_ex;
      control_d  = control_ex;
      result_d   = result_ex;
      dest_idx_d = dest_reg_index_ex;
      data_d     = (req && !we) ? mem.mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      valid_q     <= 1'b0;
      control_q   <= '0;
      result_q    <= '0;
      data_q      <= '0;
      dest_idx_q  <= '0;
      dest_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      valid_q     <= valid_d;
      control_q   <= control_d;
      result_q    <= result_d;
      data_q      <= data_d;
      dest_idx_q  <= dest_idx_d;
      dest_we_q   <= dest_we_d;
    end
  end

  assign valid_ma             = valid_q;
  assign control_ma           = control_q;
  assign result_ma            = result_q;
  assign data_ma              = data_q;
  assign dest_reg_index_ma    = dest_idx_q;
  assign dest_reg_write_en_ma = dest_we_q;

`ifdef MA_FWD_EN
  assign fwd_valid = valid_q && dest_we_q;
  assign fwd_index = dest_idx_q;
  assign fwd_data  = (control_q == LOAD_OP) ? data_q : result_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_index = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; memory side is driven by hand.
// Build with +define+MA_FWD_EN to check the forwarding outputs.
module tb_mem_access_stage;

  logic        clk;
  logic        reset_n;
  logic        valid_ex;
  logic [3:0]  control_ex;
  logic [15:0] result_ex;
  logic [15:0] reg_data_ex;
  logic [4:0]  dest_reg_index_ex;
  logic        dest_reg_write_en_ex;
  logic        stall_ma;
  logic        valid_ma;
  logic [3:0]  control_ma;
  logic [15:0] result_ma;
  logic [15:0] data_ma;
  logic [4:0]  dest_reg_index_ma;
  logic        dest_reg_write_en_ma;
  logic        fwd_valid;
  logic [4:0]  fwd_index;
  logic [15:0] fwd_data;

  mem_access_stage_if #(.DATA_W(16), .ADDR_W(16)) mem_if ();

  mem_access_stage dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .valid_ex             (valid_ex),
    .control_ex           (control_ex),
    .result_ex            (result_ex),
    .reg_data_ex          (reg_data_ex),
    .dest_reg_index_ex    (dest_reg_index_ex),
    .dest_reg_write_en_ex (dest_reg_write_en_ex),
    .stall_ma             (stall_ma),
    .mem                  (mem_if.master),
    .valid_ma             (valid_ma),
    .control_ma           (control_ma),
    .result_ma            (result_ma),
    .data_ma              (data_ma),
    .dest_reg_index_ma    (dest_reg_index_ma),
    .dest_reg_write_en_ma (dest_reg_write_en_ma),
    .fwd_valid            (fwd_valid),
    .fwd_index            (fwd_index),
    .fwd_data             (fwd_data)
  );

  localparam logic [3:0] LD = 4'b1100;
  localparam logic [3:0] ST = 4'b1110;

`ifdef MA_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int stalls;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic [15:0] r, input logic [15:0] d,
                       input logic [4:0] idx, input logic we);
    valid_ex             = v;
    control_ex           = c;
    result_ex            = r;
    reg_data_ex          = d;
    dest_reg_index_ex    = idx;
    dest_reg_write_en_ex = we;
  endtask

  task automatic mem_resp(input logic ack, input logic [15:0] rd);
    mem_if.mem_ack   = ack;
    mem_if.mem_rdata = rd;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 4'h0, 16'h0, 16'h0, 5'd0, 0);
    mem_resp(0, 16'h0);
    tick();
    check("rst_valid", valid_ma, 0);
    check("rst_result", result_ma, 0);
    check("rst_data", data_ma, 0);
    check("rst_req", mem_if.mem_req, 0);
    check("rst_stall", stall_ma, 0);
    reset_n = 1'b1;

    // ALU op
    drive(1, 4'h1, 16'h1234, 16'h0, 5'd3, 1);
    #1;
    check("alu_req", mem_if.mem_req, 0);
    check("alu_stall", stall_ma, 0);
    tick();
    check("alu_valid", valid_ma, 1);
    check("alu_result", result_ma, 16'h1234);
    check("alu_idx", dest_reg_index_ma, 3);
    check("alu_data", data_ma, 0);
    check("alu_fwdv", fwd_valid, FWD ? 1 : 0);
    check("alu_fwdd", fwd_data, FWD ? 16'h1234 : 0);

    // zero-wait load
    drive(1, LD, 16'h0040, 16'h0, 5'd5, 1);
    mem_resp(1, 16'hBEEF);
    #1;
    check("ld0_req", mem_if.mem_req, 1);
    check("ld0_we", mem_if.mem_we, 0);
    check("ld0_addr", mem_if.mem_addr, 16'h0040);
    check("ld0_wdata", mem_if.mem_wdata, 0);
    check("ld0_stall", stall_ma, 0);
    tick();
    check("ld0_valid", valid_ma, 1);
    check("ld0_ctrl", control_ma, LD);
    check("ld0_data", data_ma, 16'hBEEF);

    // store with 3 wait cycles
    drive(1, ST, 16'h0080, 16'h5A5A, 5'd0, 0);
    mem_resp(0, 16'h0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_ma) stalls++;
      check("st_we", mem_if.mem_we, 1);
      check("st_addr", mem_if.mem_addr, 16'h0080);
      check("st_wdata", mem_if.mem_wdata, 16'h5A5A);
      tick();
      check("st_bub_valid", valid_ma, 0);
      check("st_bub_we", dest_reg_write_en_ma, 0);
      check("st_bub_hold", result_ma, 16'h0040);
      reg_data_ex = 16'hFFFF;
    end
    check("st_stalls", stalls, 3);
    mem_resp(1, 16'hDEAD);
    #1;
    check("st_ack_stall", stall_ma, 0);
    check("st_ack_wdata", mem_if.mem_wdata, 16'h5A5A);
    tick();
    check("st_valid", valid_ma, 1);
    check("st_ctrl", control_ma, ST);
    check("st_result", result_ma, 16'h0080);
    check("st_data", data_ma, 0);

    // back-to-back load then store, one wait each
    stalls = 0;
    drive(1, LD, 16'h0100, 16'h0, 5'd2, 1);
    mem_resp(0, 16'h0);
    #1;
    if (stall_ma) stalls++;
    check("bb_ld_req", mem_if.mem_req, 1);
    tick();
    mem_resp(1, 16'h1111);
    #1;
    if (stall_ma) stalls++;
    tick();
    check("bb_ld_data", data_ma, 16'h1111);
    check("bb_ld_idx", dest_reg_index_ma, 2);
    drive(1, ST, 16'h0102, 16'h7777, 5'd0, 0);
    mem_resp(0, 16'h0);
    #1;
    if (stall_ma) stalls++;
    check("bb_st_req", mem_if.mem_req, 1);
    check("bb_st_we", mem_if.mem_we, 1);
    check("bb_st_addr", mem_if.mem_addr, 16'h0102);
    tick();
    mem_resp(1, 16'h2222);
    #1;
    if (stall_ma) stalls++;
    tick();
    check("bb_stalls", stalls, 2);
    check("bb_st_valid", valid_ma, 1);
    check("bb_st_data", data_ma, 0);

    // stray ack while idle
    drive(0, 4'h0, 16'h0, 16'h0, 5'd0, 0);
    mem_resp(1, 16'hDEAD);
    #1;
    check("idle_req", mem_if.mem_req, 0);
    check("idle_stall", stall_ma, 0);
    check("idle_wdata", mem_if.mem_wdata, 0);
    tick();
    check("idle_valid", valid_ma, 0);
    check("idle_data", data_ma, 0);

    // forwarding of a load
    drive(1, LD, 16'h0060, 16'h0, 5'd7, 1);
    mem_resp(1, 16'h00FF);
    tick();
    check("fwd_valid", fwd_valid, FWD ? 1 : 0);
    check("fwd_index", fwd_index, FWD ? 7 : 0);
    check("fwd_data", fwd_data, FWD ? 16'h00FF : 0);

    // reset while waiting
    drive(1, LD, 16'h0040, 16'h0, 5'd4, 1);
    mem_resp(0, 16'h0);
    tick();
    reset_n = 1'b0;
    #1;
    check("rw_req", mem_if.mem_req, 0);
    check("rw_stall", stall_ma, 0);
    check("rw_valid", valid_ma, 0);
    check("rw_ctrl", control_ma, 0);
    check("rw_result", result_ma, 0);
    check("rw_data", data_ma, 0);
    check("rw_idx", dest_reg_index_ma, 0);
    check("rw_we", dest_reg_write_en_ma, 0);
    drive(0, 4'h0, 16'h0, 16'h0, 5'd0, 0);
    tick();
    reset_n = 1'b1;
    drive(1, LD, 16'h0044, 16'h0, 5'd1, 1);
    mem_resp(1, 16'h0A0A);
    #1;
    check("rw_idle_addr", mem_if.mem_addr, 16'h0044);
    check("rw_idle_stall", stall_ma, 0);
    tick();
    check("rw_idle_data", data_ma, 16'h0A0A);
    check("rw_idle_valid", valid_ma, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access (MA) pipeline stage between the execute stage and write-back. Issues load/store requests to a variable-latency data memory over a req/ack handshake and stalls upstream until the access completes. Registers the EX-stage control, ALU result, load data and destination-register fields into the MA pipeline register, inserting bubbles while stalled.

## Interface
- DATA_W, 16, datapath and memory data width
- ADDR_W, 16, memory address width; must satisfy ADDR_W <= DATA_W
- REG_IDX_W, 5, destination register index width
- CTRL_W, 4, opcode/control width
- LOAD_OP, 4'b1100, control value for a load
- STORE_OP, 4'b1110, control value for a store

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- valid_ex  in  1  EX slot holds a real instruction
- control_ex  in  CTRL_W  EX opcode
- result_ex  in  DATA_W  ALU result; effective address for load/store
- reg_data_ex  in  DATA_W  store data
- dest_reg_index_ex  in  REG_IDX_W  destination register
- dest_reg_write_en_ex  in  1  destination write enable
- stall_ma  out  1  upstream must hold all *_ex inputs this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load; valid with mem_req
- mem_addr  out  ADDR_W  result_ex[ADDR_W-1:0]
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- valid_ma, control_ma, result_ma, data_ma, dest_reg_index_ma, dest_reg_write_en_ma  out  1/CTRL_W/DATA_W/DATA_W/REG_IDX_W/1  MA pipeline register

## Operation
- Memory op = valid_ex && (control_ex == LOAD_OP || control_ex == STORE_OP).
- FSM states: IDLE, WAIT. Reset -> IDLE.
- IDLE, no memory op: mem_req=0; at edge MA register loads EX fields, valid_ma=valid_ex, data_ma=0.
- IDLE, memory op: mem_req=1, mem_we, mem_addr, mem_wdata driven combinationally from EX inputs; the same values are captured into a request latch.
  - mem_ack=1 same cycle: complete; MA register loads EX fields, data_ma=mem_rdata for load, 0 for store; stay IDLE; stall_ma=0.
  - mem_ack=0: stall_ma=1; MA loads bubble; -> WAIT.
- WAIT: mem_req=1, mem_we/mem_addr/mem_wdata driven from the request latch (stable regardless of inputs).
  - mem_ack=0: stall_ma=1, bubble, remain WAIT.
  - mem_ack=1: stall_ma=0; MA register loads EX fields (held by upstream) plus data_ma as above; -> IDLE.
- Bubble: valid_ma=0, dest_reg_write_en_ma=0; control_ma, result_ma, data_ma, dest_reg_index_ma hold their previous values.
- stall_ma = mem_req && !mem_ack (combinational on mem_ack).
- mem_ack while mem_req=0 is ignored.
- mem_wdata is 0 and mem_we is 0 whenever mem_req=0.

## Timing
- Reset values: state IDLE, all MA outputs 0, request latch 0; mem_req, mem_we, stall_ma 0.
- Non-memory op and zero-wait access: 1-cycle latency EX -> MA.
- N-cycle memory: N stall cycles, N bubbles, result in MA at the edge ending the ack cycle.
- Back-to-back memory ops: the next op issues in IDLE the cycle after completion; no dead cycle.
- reset_n asserted in WAIT: immediate IDLE, mem_req drops asynchronously; the outstanding request is abandoned and memory must discard it.

## Configuration
- MA_FWD_EN defined: adds outputs fwd_valid (1), fwd_index (REG_IDX_W), fwd_data (DATA_W), driven from the MA register: fwd_valid = valid_ma && dest_reg_write_en_ma; fwd_data = data_ma if control_ma == LOAD_OP, else result_ma.
- Not defined: ports exist, tied to 0.

## Test plan
- Reset mid-WAIT: load to 0x0040, no ack, pull reset_n low -> mem_req=0 same cycle; all MA outputs 0; state IDLE after release.
- ALU op result 0x1234, dest r3 -> next cycle valid_ma=1, result_ma=0x1234, dest_reg_index_ma=3, mem_req never high.
- Load 0x0040, mem_ack same cycle with rdata 0xBEEF -> no stall; next cycle data_ma=0xBEEF, control_ma=LOAD_OP.
- Store 0x0080 data 0x5A5A, ack after 3 cycles -> stall_ma high 3 cycles, mem_addr/wdata stable, 3 bubbles with dest_reg_write_en_ma=0, then valid_ma=1.
- Load then store back-to-back, each 1 wait cycle -> 2 stall cycles total, requests on consecutive issue, correct data_ma for load, 0 for store.
- MA_FWD_EN build: load to r7 returning 0x00FF -> fwd_valid=1, fwd_index=7, fwd_data=0x00FF; without macro all fwd_* stay 0.
